// File: rtl/muldiv_sequencer.sv
// Multi-cycle M-extension unit: radix-2 shift-add multiplier and restoring
// divider with RISC-V sign/corner-case fixups, sequenced by a small FSM.
`timescale 1ns/1ps
module muldiv_sequencer #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       mul_en,
    input  logic [3:0]       div_en,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             resp_valid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_FIXUP = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

    // W ops: sign-extend the low half-word result to full width
    function automatic logic [XLEN-1:0] fit_w(input logic w, input logic [XLEN-1:0] v);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    logic [2:0]       state;
    logic [CW-1:0]    count;
    logic [XLEN-1:0]  opa;       // multiplicand (shifts left) or divisor magnitude
    logic [XLEN-1:0]  opb;       // multiplier (shifts right) or dividend/quotient
    logic [XLEN-1:0]  acc;       // product accumulator or partial remainder
    logic [XLEN-1:0]  fin;
    logic [XLEN-1:0]  last_res;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] last_tag;
    logic             is_mul, is_w, sel_rem, neg_q, neg_r;

    logic             mul_sel, w_op, sgn_op, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]  ext_a, ext_b, mag_a, mag_b, dvd_init, special_raw;

    // Operand preparation and special-case detection at accept time
    always_comb begin
        mul_sel  = (mul_en == 2'b01) || (mul_en == 2'b11);
        w_op     = mul_sel ? mul_en[1] : div_en[3];
        sgn_op   = !mul_sel && !div_en[0];
        if (w_op) begin
            ext_a = sgn_op ? {{HALF{src_a[HALF-1]}}, src_a[HALF-1:0]} : {{HALF{1'b0}}, src_a[HALF-1:0]};
            ext_b = sgn_op ? {{HALF{src_b[HALF-1]}}, src_b[HALF-1:0]} : {{HALF{1'b0}}, src_b[HALF-1:0]};
        end else begin
            ext_a = src_a;
            ext_b = src_b;
        end
        sa       = sgn_op && ext_a[XLEN-1];
        sb       = sgn_op && ext_b[XLEN-1];
        mag_a    = sa ? -ext_a : ext_a;
        mag_b    = sb ? -ext_b : ext_b;
        // W dividends start in the upper half so MSB-first iteration needs only HALF steps
        dvd_init = w_op ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
        div_zero = (ext_b == '0);
        div_ovf  = sgn_op && (ext_b == '1) && (ext_a == (w_op ? MIN_W : MIN_D));
        if (div_zero)
            special_raw = div_en[1] ? ext_a : '1;
        else
            special_raw = div_en[1] ? '0 : ext_a;
    end

    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] mul_sum, quo_f, rem_f, raw_fix;

    // One iteration step for each engine, plus the sign/select fixup
    always_comb begin
        rem_sh  = {acc, opb[XLEN-1]};
        diff    = rem_sh - {1'b0, opa};
        mul_sum = acc + (opb[0] ? opa : '0);
        quo_f   = neg_q ? -opb : opb;
        rem_f   = neg_r ? -acc : acc;
        raw_fix = is_mul ? acc : (sel_rem ? rem_f : quo_f);
    end

    // Sequencer FSM and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            count    <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            fin      <= '0;
            last_res <= '0;
            tag_q    <= '0;
            last_tag <= '0;
            is_mul   <= 1'b0;
            is_w     <= 1'b0;
            sel_rem  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && (mul_sel || div_en[2])) begin
                        tag_q   <= tag_in;
                        is_mul  <= mul_sel;
                        is_w    <= w_op;
                        sel_rem <= div_en[1];
                        neg_q   <= sa ^ sb;
                        neg_r   <= sa;
                        count   <= w_op ? CW'(HALF-1) : CW'(XLEN-1);
                        acc     <= '0;
                        if (mul_sel) begin
                            opa   <= ext_a;
                            opb   <= ext_b;
                            state <= S_MUL;
                        end else if (div_zero || div_ovf) begin
                            fin   <= fit_w(w_op, special_raw);
                            state <= S_DONE;
                        end else begin
                            opa   <= mag_b;
                            opb   <= dvd_init;
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= mul_sum;
                    opa   <= opa << 1;
                    opb   <= opb >> 1;
                    count <= count - 1'b1;
                    if (count == '0) state <= S_FIXUP;
                end
                S_DIV: begin
                    acc   <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                    opb   <= {opb[XLEN-2:0], !diff[XLEN]};
                    count <= count - 1'b1;
                    if (count == '0) state <= S_FIXUP;
                end
                S_FIXUP: begin
                    fin   <= fit_w(is_w, raw_fix);
                    state <= S_DONE;
                end
                S_DONE: begin
                    last_res <= fin;
                    last_tag <= tag_q;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake and response outputs; result/tag hold outside the pulse
    always_comb begin
        req_ready  = (state == S_IDLE);
        busy       = (state != S_IDLE);
        resp_valid = (state == S_DONE) && !flush;
        result     = resp_valid ? fin : last_res;
        tag_out    = resp_valid ? tag_q : last_tag;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized + directed bench for muldiv_sequencer against an arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  mul_en;
    logic [3:0]  div_en;
    logic [63:0] src_a, src_b;
    logic [4:0]  tag_in;
    logic        flush;
    logic        busy;
    logic        resp_valid;
    logic [63:0] result;
    logic [4:0]  tag_out;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_sequencer #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .mul_en(mul_en), .div_en(div_en), .src_a(src_a), .src_b(src_b),
        .tag_in(tag_in), .flush(flush), .busy(busy), .resp_valid(resp_valid),
        .result(result), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: RISC-V M-extension semantics computed with native arithmetic
    task automatic ref_model(input logic [1:0] me, input logic [3:0] de,
                             input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] res, output int lat);
        logic [63:0] p;
        bit w, sgn, rem;
        if (me == 2'b01 || me == 2'b11) begin
            p   = a * b;
            res = me[1] ? sext32(p[31:0]) : p;
            lat = me[1] ? 34 : 66;
            return;
        end
        w   = de[3];
        sgn = !de[0];
        rem = de[1];
        if (w) begin
            logic [31:0] a32, b32, r32;
            int sa32, sb32;
            a32 = a[31:0]; b32 = b[31:0];
            sa32 = a32; sb32 = b32;
            lat = 34;
            if (b32 == 0) begin
                r32 = rem ? a32 : 32'hFFFF_FFFF; lat = 1;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                r32 = rem ? 32'h0 : a32; lat = 1;
            end else if (sgn) begin
                r32 = rem ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            end else begin
                r32 = rem ? a32 % b32 : a32 / b32;
            end
            res = sext32(r32);
        end else begin
            longint sa64, sb64;
            sa64 = a; sb64 = b;
            lat = 66;
            if (b == 0) begin
                res = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF; lat = 1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                res = rem ? 64'h0 : a; lat = 1;
            end else if (sgn) begin
                res = rem ? 64'(sa64 % sb64) : 64'(sa64 / sb64);
            end else begin
                res = rem ? a % b : a / b;
            end
        end
    endtask

    // Issue one op (called at a negedge) and check latency, value, tag, single pulse
    task automatic run_op(input string name, input logic [1:0] me, input logic [3:0] de,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] tg,
                          input logic [63:0] exp_res, input int exp_lat);
        int first, pulses;
        logic [63:0] got_res;
        logic [4:0]  got_tag;
        first = 0; pulses = 0; got_res = '0; got_tag = '0;
        req_valid = 1'b1; mul_en = me; div_en = de; src_a = a; src_b = b; tag_in = tg;
        @(posedge clk);
        #1 req_valid = 1'b0; mul_en = 2'b00; div_en = 4'b0000;
        for (int k = 1; k <= exp_lat + 2; k++) begin
            @(negedge clk);
            if (k == 1) check({name, ".busy"}, 64'(busy), 64'd1);
            if (resp_valid) begin
                pulses++;
                if (first == 0) begin
                    first = k; got_res = result; got_tag = tag_out;
                end
            end
        end
        check({name, ".lat"},    64'(first),   64'(exp_lat));
        check({name, ".pulses"}, 64'(pulses),  64'd1);
        check({name, ".result"}, got_res,      exp_res);
        check({name, ".tag"},    64'(got_tag), 64'(tg));
        check({name, ".hold"},   result,       exp_res);
        check({name, ".ready"},  64'(req_ready), 64'd1);
    endtask

    task automatic run_rand(input string name, input logic [1:0] me, input logic [3:0] de,
                            input logic [63:0] a, input logic [63:0] b, input logic [4:0] tg);
        logic [63:0] er;
        int el;
        ref_model(me, de, a, b, er, el);
        run_op(name, me, de, a, b, tg, er, el);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom % 7)
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return sext32(32'($urandom_range(0, 40)) - 32'd20);
            4: return {$urandom, $urandom};
            5: return 64'hFFFF_FFFF_8000_0000;
            default: return {32'($urandom % 4), $urandom};
        endcase
    endfunction

    initial begin
        resetn = 1'b0; req_valid = 1'b0; mul_en = 2'b00; div_en = 4'b0000;
        src_a = '0; src_b = '0; tag_in = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.ready", 64'(req_ready),  64'd1);
        check("rst.busy",  64'(busy),       64'd0);
        check("rst.resp",  64'(resp_valid), 64'd0);
        check("rst.result", result,         64'd0);
        check("rst.tag",   64'(tag_out),    64'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_op("mul",   2'b01, 4'b0000, 64'd3, -64'sd5, 5'd7, 64'hFFFF_FFFF_FFFF_FFF1, 66);
        run_op("mulw0", 2'b11, 4'b0000, 64'h8000_0000, 64'd2, 5'd3, 64'h0, 34);
        run_op("mulw1", 2'b11, 4'b0000, 64'h4000_0000, 64'd2, 5'd4, 64'hFFFF_FFFF_8000_0000, 34);
        run_op("div",   2'b00, 4'b0100, -64'sd7, 64'd2, 5'd5, -64'sd3, 66);
        run_op("rem",   2'b00, 4'b0110, -64'sd7, 64'd2, 5'd6, -64'sd1, 66);
        run_op("divu",  2'b00, 4'b0101, 64'd7, 64'd2, 5'd8, 64'd3, 66);
        run_op("remu",  2'b00, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd9, 64'd15, 66);
        run_op("divu0", 2'b00, 4'b0101, 64'd1234, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem0",  2'b00, 4'b0110, 64'd9, 64'd0, 5'd11, 64'd9, 1);
        run_op("divov", 2'b00, 4'b0100, 64'h8000_0000_0000_0000, -64'sd1, 5'd12, 64'h8000_0000_0000_0000, 1);
        run_op("remov", 2'b00, 4'b0110, 64'h8000_0000_0000_0000, -64'sd1, 5'd13, 64'h0, 1);
        run_op("divw",  2'b00, 4'b1100, 64'h1_0000_0007, 64'd2, 5'd14, 64'd3, 34);
        run_op("remw",  2'b00, 4'b1110, -64'sd7, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("priority", 2'b01, 4'b0100, 64'd6, 64'd7, 5'd16, 64'd42, 66);

        // Request with no valid op code is ignored
        req_valid = 1'b1; mul_en = 2'b10; div_en = 4'b0011;
        @(posedge clk);
        #1 req_valid = 1'b0; mul_en = 2'b00; div_en = 4'b0000;
        @(negedge clk);
        check("ignore.busy",  64'(busy),      64'd0);
        check("ignore.ready", 64'(req_ready), 64'd1);

        // Flush at cycle 20 of a DIV, then a MUL issued in cycle 21
        begin
            int pulses = 0;
            req_valid = 1'b1; div_en = 4'b0100; src_a = 64'd1000; src_b = 64'd3; tag_in = 5'd20;
            @(posedge clk);
            #1 req_valid = 1'b0; div_en = 4'b0000;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (resp_valid) pulses++;
            end
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            @(negedge clk);
            if (resp_valid) pulses++;
            check("flush.pulses", 64'(pulses),   64'd0);
            check("flush.ready",  64'(req_ready), 64'd1);
            check("flush.busy",   64'(busy),      64'd0);
            run_op("postflush", 2'b01, 4'b0000, 64'd11, 64'd13, 5'd21, 64'd143, 66);
        end

        // Flush during the DONE cycle of a special-case op suppresses the pulse
        req_valid = 1'b1; div_en = 4'b0101; src_a = 64'd5; src_b = 64'd0; tag_in = 5'd22;
        @(posedge clk);
        #1 req_valid = 1'b0; div_en = 4'b0000; flush = 1'b1;
        #1 check("flushdone.resp", 64'(resp_valid), 64'd0);
        check("flushdone.tag", 64'(tag_out), 64'd21);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flushdone.ready", 64'(req_ready), 64'd1);
        check("flushdone.hold",  result, 64'd143);

        // Asynchronous reset in the middle of a MUL
        req_valid = 1'b1; mul_en = 2'b01; src_a = 64'd9; src_b = 64'd9; tag_in = 5'd23;
        @(posedge clk);
        #1 req_valid = 1'b0; mul_en = 2'b00;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("arst.busy",   64'(busy),      64'd0);
        check("arst.ready",  64'(req_ready), 64'd1);
        check("arst.result", result,         64'd0);
        check("arst.tag",    64'(tag_out),   64'd0);
        #2 resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] me;
            logic [3:0] de;
            if ($urandom % 3 == 0) begin
                me = ($urandom % 2) ? 2'b11 : 2'b01;
                de = 4'($urandom);
            end else begin
                me = ($urandom % 2) ? 2'b00 : 2'b10;
                de = {1'($urandom), 1'b1, 2'($urandom)};
            end
            run_rand($sformatf("rand%0d", i), me, de, pick(), pick(), 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
